gb_fb_writer: RTL
=================

Name: gb_fb_writer

Overview:
- Downstream consumer of the PPU pixel stream (2-bit colour index plus valid strobe).
- Maps each index through the BGP palette and packs 4 shaded pixels per byte (160x144 -> 5760 bytes).
- Queues each byte with its framebuffer address in a small FIFO and drains it to the framebuffer write port via valid/ready.
- Sits between the PPU and the dual-port framebuffer RAM read by the video scan-out.

Parameters:
- FIFO_DEPTH, 8, entries in the write queue (power of two, >=2).
- FB_BYTES, 5760, bytes per frame (160*144/4); address wraps here.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- lcd_en  in  1  LCDC[7]; low holds the packer idle.
- frame_start  in  1  one-cycle pulse at start of frame (V_BLANK exit); resyncs position.
- px  in  2  PPU colour index.
- px_valid  in  1  px is valid this cycle.
- bgp  in  8  palette register FF47.
- fb_addr  out  13  framebuffer byte address.
- fb_data  out  8  packed byte: first pixel in [7:6], fourth in [1:0].
- fb_we  out  1  write valid (FIFO not empty).
- fb_ready  in  1  framebuffer accepts write this cycle.
- frame_done  out  1  one-cycle pulse when byte FB_BYTES-1 is pushed.
- overflow  out  1  sticky: byte dropped because FIFO full.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, async): fb_we=0, fb_addr=0, fb_data=0, frame_done=0, overflow=0; pack count=0, byte address=0, FIFO empty.
- Shade: shade = bgp[2*px+1 : 2*px], sampled in the same cycle as px_valid.
- Packer: 2-bit slot counter (0..3) plus 8-bit shift accumulator. On an accepted pixel the shade shifts in at the LSB end and the slot counter increments.
- Byte complete: on the cycle slot==3 is accepted, {addr_cnt, packed byte} is pushed to the FIFO at the next edge, slot returns to 0, and addr_cnt increments.
- Address wrap: addr_cnt wraps from FB_BYTES-1 to 0. frame_done pulses on the push of byte FB_BYTES-1.
- Latency: 4th pixel accepted in cycle N -> fb_we=1 with that byte in cycle N+1 if the FIFO was empty (show-ahead head).
- Drain: fb_we = !empty; fb_addr/fb_data show the head entry. The entry pops on fb_we && fb_ready. Outputs must be stable while fb_we=1 and fb_ready=0.
- Full FIFO: a push while full with no pop that cycle drops the byte and sets overflow, but addr_cnt still advances so later bytes land correctly. Push while full with a pop in the same cycle is accepted.
- Empty FIFO: fb_ready is ignored; no pop.
- frame_start: synchronously clears slot, accumulator and addr_cnt; any partial byte is discarded.
  - frame_start together with px_valid in the same cycle: frame_start wins and the pixel is discarded.
  - The FIFO is not flushed; queued bytes still drain.
- lcd_en=0: px_valid is ignored and the packer/addr_cnt are held at 0. The FIFO continues draining.
- overflow: ovf_clr clears it. If ovf_clr and a new drop occur in the same cycle, set wins.
- Packer FSM (enum): IDLE (lcd_en=0) -> ACTIVE on lcd_en=1; ACTIVE -> IDLE on lcd_en=0. frame_start is handled in both states.

Decomposition:
- Shared package gb_video_pkg holds:
  - LCD_W=160, LCD_H=144, FB_BYTES.
  - Typedef fb_entry_t {logic [12:0] addr; logic [7:0] data;}.
  - Packer state enum.
- Sub-module gb_fb_fifo: synchronous show-ahead FIFO of fb_entry_t, parameterised by depth. Ports: push, pop, full, empty, head; push-while-full-with-pop accepted.

Test Plan:
- bgp=8'hE4; pixels 0,1,2,3 on consecutive cycles, fb_ready=1 -> one write: addr 0, data 8'h1B, fb_we high exactly one cycle, on the cycle after the 4th pixel.
- bgp=8'h1B (inverted palette); pixels 3,3,0,0 -> data 8'h0F. Change bgp mid-byte -> each pixel uses the bgp value current at its own acceptance.
- Stream 23040 pixels with fb_ready=1 -> 5760 writes, addr 0..5759 in order, frame_done single pulse with addr 5759, next byte at addr 0.
- Hold fb_ready=0 and push 9 bytes (FIFO_DEPTH=8) -> overflow=1, 8 entries retained. Release fb_ready -> addrs 0..7 written; the next pushed byte has addr 9. ovf_clr -> overflow=0.
- 2 pixels, then frame_start asserted together with a px_valid -> no write, addr_cnt=0; next 4 pixels produce addr 0.
- Assert rst=0 mid-drain with 3 entries queued -> fb_we drops to 0 immediately (asynchronously); after release the FIFO is empty and the first byte goes to addr 0.

Source files
------------

// File: rtl/gb_video_pkg.sv
// Shared video definitions: LCD geometry, framebuffer entry type, packer states.
package gb_video_pkg;

  localparam int LCD_W    = 160;
  localparam int LCD_H    = 144;
  localparam int FB_BYTES = (LCD_W * LCD_H) / 4;
  localparam int ADDR_W   = 13;

  // One queued framebuffer write: byte address plus four packed shades.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } fb_entry_t;

  // Packer is IDLE while the LCD is off, ACTIVE while it is on.
  typedef enum logic {
    PK_IDLE   = 1'b0,
    PK_ACTIVE = 1'b1
  } pk_state_t;

  // Map a 2-bit colour index through a BGP-style palette register.
  function automatic logic [1:0] shade_of(input logic [7:0] pal, input logic [1:0] idx);
    logic [1:0] s;
    case (idx)
      2'd0:    s = pal[1:0];
      2'd1:    s = pal[3:2];
      2'd2:    s = pal[5:4];
      default: s = pal[7:6];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gb_fb_fifo.sv
// Synchronous show-ahead FIFO of framebuffer entries. The head entry is
// visible whenever empty is low; a push while full is taken only if a pop
// happens in the same cycle.
module gb_fb_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  gb_video_pkg::fb_entry_t wdata,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output gb_video_pkg::fb_entry_t head
);
  import gb_video_pkg::*;

  localparam int PW = $clog2(DEPTH);

  fb_entry_t     mem [DEPTH];
  logic [PW:0]   wptr;
  logic [PW:0]   rptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[PW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PW+1)'(1);
      if (do_pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gb_fb_writer.sv
// PPU pixel stream to framebuffer writer: palette-maps each pixel, packs four
// shades per byte, tags each byte with its framebuffer address and drains the
// queue to the RAM write port.
//
// Write handshake: fb_we is high whenever an entry is queued, and fb_addr /
// fb_data hold that entry steady until the cycle fb_we && fb_ready, at whose
// closing edge the entry is consumed. fb_ready is ignored while fb_we is low.
module gb_fb_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_BYTES   = 5760
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_en,
  input  logic        frame_start,
  input  logic [1:0]  px,
  input  logic        px_valid,
  input  logic [7:0]  bgp,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        frame_done,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic        pk_state
);
  import gb_video_pkg::*;

  pk_state_t   state;
  pk_state_t   state_next;
  logic        run;
  logic        accept;
  logic [1:0]  shade;
  logic [1:0]  slot;
  logic [7:0]  acc;
  logic [12:0] addr_cnt;
  logic        byte_done;
  logic        last_byte;
  fb_entry_t   push_entry;
  fb_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;

  // Packer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PK_IDLE;
    else      state <= state_next;
  end

  // Packer next state: follows the LCD enable.
  always_comb begin
    state_next = state;
    case (state)
      PK_IDLE:   if (lcd_en)  state_next = PK_ACTIVE;
      PK_ACTIVE: if (!lcd_en) state_next = PK_IDLE;
      default:   state_next = PK_IDLE;
    endcase
  end

  assign pk_state = state;

  // The packer runs in any cycle where the LCD is (or is becoming) enabled;
  // frame_start takes priority over a coincident pixel.
  assign run       = (state_next == PK_ACTIVE);
  assign accept    = run && px_valid && !frame_start;
  assign shade     = shade_of(bgp, px);
  assign byte_done = accept && (slot == 2'd3);
  assign last_byte = (addr_cnt == 13'(FB_BYTES - 1));

  assign push_entry.addr = addr_cnt;
  assign push_entry.data = {acc[5:0], shade};

  // Slot counter, shade accumulator and byte address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot     <= '0;
      acc      <= '0;
      addr_cnt <= '0;
    end else if (!run || frame_start) begin
      slot     <= '0;
      acc      <= '0;
      addr_cnt <= '0;
    end else if (accept) begin
      acc  <= {acc[5:0], shade};
      slot <= slot + 2'd1;
      if (slot == 2'd3) begin
        // Address advances even if the byte is dropped, so later bytes
        // still land at their correct position.
        addr_cnt <= last_byte ? 13'd0 : addr_cnt + 13'd1;
      end
    end
  end

  assign pop  = !fifo_empty && fb_ready;
  assign drop = byte_done && fifo_full && !pop;

  // End-of-frame pulse and sticky overflow flag (a new drop beats a clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= byte_done && last_byte;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  gb_fb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (byte_done),
    .wdata (push_entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign fb_we   = !fifo_empty;
  assign fb_addr = fifo_empty ? 13'd0 : head.addr;
  assign fb_data = fifo_empty ? 8'd0  : head.data;

endmodule
